cache_req_queue: RTL

In-order request queue between the core (or the cache exerciser) and the data cache. It accepts single-cycle read/write request pulses, buffers up to DEPTH of them, and issues them to the cache one at a time, holding each until the cache's finish pulse. Writes are posted: the requester sees write-finish immediately and can keep streaming. Reads return data in program order, and a read is never issued ahead of an older write.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/req_fifo.sv | 55 +++++
 rtl/cache_req_queue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and widths for the data-cache request path.
// Address layout is {tag, index, offset}; the queue itself treats it as opaque.
package cache_pkg;

  localparam int ADDR_W   = 27;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 13;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 4;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } issue_state_e;

endpackage

// File: rtl/req_fifo.sv
// Circular FIFO of req_t with up to two pushes and one pop per cycle.
// The second push slot is only meaningful together with the first; it lands behind it.
module req_fifo
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push_a,
  input  req_t             i_push_a_data,
  input  logic             i_push_b,
  input  req_t             i_push_b_data,
  input  logic             i_pop,
  output req_t             o_head,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next
);

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_tail_p1;
  logic [1:0]       w_push_n;
  logic             w_pop;

  assign w_tail_p1    = r_tail + PTR_W'(1);
  assign w_push_n     = {1'b0, i_push_a} + {1'b0, i_push_b};
  assign w_pop        = i_pop && (r_count != '0);
  assign o_count_next = r_count + CNT_W'(w_push_n) - CNT_W'(w_pop);
  assign o_head       = r_mem[r_head];
  assign o_count      = r_count;

  // Storage carries no reset; entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push_a) r_mem[r_tail] <= i_push_a_data;
    if (i_push_b) r_mem[w_tail_p1] <= i_push_b_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_head  <= r_head + PTR_W'(w_pop);
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/cache_req_queue.sv
// In-order request queue between the core and the data cache.
// Writes are posted; one cache transaction is outstanding at a time, so reads never pass older writes.
module cache_req_queue
  import cache_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              core2q_rd_en,
  input  logic [ADDR_W-1:0] core2q_rd_addr,
  input  logic              core2q_wr_en,
  input  logic [ADDR_W-1:0] core2q_wr_addr,
  input  logic [DATA_W-1:0] core2q_wr_data,
  output logic              q2core_wr_fin,
  output logic              q2core_rd_fin,
  output logic [DATA_W-1:0] q2core_rd_data,
  output logic              q2core_full,
  output logic              q2core_overflow,
  output logic              q2cache_rd_en,
  output logic [ADDR_W-1:0] q2cache_rd_addr,
  output logic              q2cache_wr_en,
  output logic [ADDR_W-1:0] q2cache_wr_addr,
  output logic [DATA_W-1:0] q2cache_wr_data,
  input  logic              cache2q_rd_fin,
  input  logic              cache2q_wr_fin,
  input  logic [DATA_W-1:0] cache2q_rd_data
);

  issue_state_e      r_state;
  issue_state_e      w_next_state;
  logic              r_cur_is_wr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_fin;
  logic              r_rd_fin;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_full;
  logic              r_overflow;

  logic              w_acc_wr;
  logic              w_acc_rd;
  logic              w_push_a;
  logic              w_push_b;
  req_t              w_wr_req;
  req_t              w_rd_req;
  req_t              w_push_a_data;
  req_t              w_head;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_issue;
  logic              w_pop;

  // A simultaneous read and write enqueue as two entries, write ahead of read.
  assign w_acc_wr      = core2q_wr_en && !r_full;
  assign w_acc_rd      = core2q_rd_en && !r_full;
  assign w_wr_req      = '{is_wr: 1'b1, addr: core2q_wr_addr, data: core2q_wr_data};
  assign w_rd_req      = '{is_wr: 1'b0, addr: core2q_rd_addr, data: '0};
  assign w_push_a      = w_acc_wr || w_acc_rd;
  assign w_push_b      = w_acc_wr && w_acc_rd;
  assign w_push_a_data = w_acc_wr ? w_wr_req : w_rd_req;

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .i_push_a     (w_push_a),
    .i_push_a_data(w_push_a_data),
    .i_push_b     (w_push_b),
    .i_push_b_data(w_rd_req),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_count != '0) begin
          w_issue      = 1'b1;
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cur_is_wr ? cache2q_wr_fin : cache2q_rd_fin) begin
          w_pop        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // During the issue cycle the head is presented directly; afterwards the latched copy holds.
  assign q2cache_wr_en   = w_issue && w_head.is_wr;
  assign q2cache_rd_en   = w_issue && !w_head.is_wr;
  assign q2cache_wr_addr = q2cache_wr_en ? w_head.addr : r_wr_addr;
  assign q2cache_wr_data = q2cache_wr_en ? w_head.data : r_wr_data;
  assign q2cache_rd_addr = q2cache_rd_en ? w_head.addr : r_rd_addr;

  assign q2core_wr_fin   = r_wr_fin;
  assign q2core_rd_fin   = r_rd_fin;
  assign q2core_rd_data  = r_rd_data;
  assign q2core_full     = r_full;
  assign q2core_overflow = r_overflow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cur_is_wr <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_fin    <= 1'b0;
      r_rd_fin    <= 1'b0;
      r_rd_data   <= '0;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wr_fin   <= w_acc_wr;
      r_rd_fin   <= w_pop && !r_cur_is_wr;
      r_full     <= w_count_next > CNT_W'(DEPTH - 2);
      r_overflow <= r_overflow || (r_full && (core2q_rd_en || core2q_wr_en));
      if (w_issue) begin
        r_cur_is_wr <= w_head.is_wr;
        if (w_head.is_wr) begin
          r_wr_addr <= w_head.addr;
          r_wr_data <= w_head.data;
        end else begin
          r_rd_addr <= w_head.addr;
        end
      end
      if (w_pop && !r_cur_is_wr) r_rd_data <= cache2q_rd_data;
    end
  end

endmodule
